alu_result_uart_tx: RTL
=======================

# alu_result_uart_tx

Serial reporter for the ALU test harness. It captures a 32-bit ALU result and its NZC flags on a start pulse and transmits them to a host as a 14-character ASCII line over an 8N1 UART TX pin. It sits beside the switch/button operand-entry FSM and is the board-to-host output path, so full 32-bit results can be read without the 4-bit LED limit.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal values are 2 and above.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request to send a report. Sampled every edge; accepted only when `busy` is low.
- `result` input, 32 bits: ALU result to report. Latched on accept.
- `nzc` input, 3 bits: flags; [2]=N, [1]=Z, [0]=C. Latched on accept.
- `busy` output, 1 bit: high while a line is being transmitted.
- `done` output, 1 bit: one-cycle pulse at end of line.
- `tx` output, 1 bit: UART serial line; idles high.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0; FSM in IDLE; char index 0; bit counter 0.
- Accept: at an edge where registered `busy`=0 and `start`=1:
  - latch `result` and `nzc` into shadow registers;
  - set `busy`=1 and begin the start bit of char 0.
- Input changes after accept have no effect on the line in flight.
- `start` while `busy`=1 is ignored. It is not queued.
- Line format, 14 chars in order:
  - chars 0–7: hex nibbles of `result`, MSB nibble first. 0–9 map to 0x30–0x39; A–F map to uppercase 0x41–0x46.
  - char 8: space, 0x20.
  - char 9: 'N' (0x4E) if N else '-' (0x2D).
  - char 10: 'Z' (0x5A) if Z else '-'.
  - char 11: 'C' (0x43) if C else '-'.
  - char 12: CR, 0x0D.
  - char 13: LF, 0x0A.
- Char frame: start bit 0, then 8 data bits LSB first, then stop bit 1. No parity. The next char's start bit follows the stop bit immediately, with no idle gap.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START (next char) if char index < 13.
  - STOP → IDLE if char index = 13. In that case pulse `done` and clear `busy`.
- Char index is 4 bits and counts 0..13, then resets to 0 on return to IDLE. It never wraps past 13.
- Reset mid-line: on the reset edge, `tx`=1, `busy`=0, and the line is abandoned. No `done` is produced, and the next accept starts from char 0.
- Reset has priority over `start` at the same edge.

## Timing
- Accept edge E0: immediately after it, `busy`=1 and `tx`=0 (start bit of char 0). There is no extra latency cycle.
- Every bit holds `tx` for exactly CLKS_PER_BIT cycles. A char is 10·CLKS_PER_BIT cycles; a line is 140·CLKS_PER_BIT cycles.
- Edge E0+140·CLKS_PER_BIT: after it, `busy`=0, `done`=1 and `tx`=1. `done` returns to 0 after the next edge.
- Earliest back-to-back accept is edge E0+140·CLKS_PER_BIT+1, i.e. `start` held high through the `done` cycle. Its start bit then follows a 1-cycle idle-high gap.
- `busy` and `done` are never both high. `done` is never high for more than 1 cycle.
- `tx` is registered, so there are no combinational glitches.

## Test plan
- Reset: assert `rst` 3 cycles with `start`=1 → `tx`=1, `busy`=0, `done`=0 throughout; no accept until the cycle after `rst` falls.
- Basic line: CLKS_PER_BIT=4, `result`=0x000000A5, `nzc`=3'b000, 1-cycle `start` → decoded bytes "000000A5 ---\r\n"; `done` pulses exactly 560 cycles after accept.
- Flags and hex: `result`=0xDEADBEEF, `nzc`=3'b101 → "DEADBEEF N-C\r\n". Then `result`=0xFFFFFFFF, `nzc`=3'b111 → "FFFFFFFF NZC\r\n".
- Bit timing: CLKS_PER_BIT=4 → the start bit of char 0 is low exactly 4 cycles starting the cycle after accept. Each stop bit is high exactly 4 cycles, with no idle gap between chars.
- Busy isolation: mid-line, change `result` to 0x12345678 and pulse `start` → the line still carries the originally latched value; exactly one `done`; no second line.
- Reset mid-line: assert `rst` during char 5 → `tx`=1 and `busy`=0 after the edge, no `done`. A new `start` with `result`=0x00000001, `nzc`=3'b010 → complete "00000001 -Z-\r\n".

Source files
------------

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: sends a latched 32-bit result + NZC as "XXXXXXXX NZC\r\n" over 8N1 UART; ports clk, rst, start, result[31:0], nzc[2:0] in; busy, done, tx out
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [2:0]  nzc,
  output logic        busy,
  output logic        done,
  output logic        tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] idx_q, idx_d;
  logic [31:0] res_q, res_d;
  logic [2:0] nzc_q, nzc_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] nib;
  logic [7:0] hex, ch;
  logic tick;
  always_comb begin
    nib = res_q[{~idx_q[2:0], 2'b00} +: 4];
    hex = nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    ch = idx_q < 4'd8  ? hex :
         idx_q == 4'd8  ? 8'h20 :
         idx_q == 4'd9  ? (nzc_q[2] ? 8'h4E : 8'h2D) :
         idx_q == 4'd10 ? (nzc_q[1] ? 8'h5A : 8'h2D) :
         idx_q == 4'd11 ? (nzc_q[0] ? 8'h43 : 8'h2D) :
         idx_q == 4'd12 ? 8'h0D : 8'h0A;
    tick = cnt_q == LAST;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    idx_d = idx_q;
    res_d = res_q;
    nzc_d = nzc_q;
    tx_d = tx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = START;
        res_d = result;
        nzc_d = nzc;
        busy_d = 1'b1;
        tx_d = 1'b0;
        cnt_d = '0;
        idx_d = '0;
      end
    end else if (!tick) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d = '0;
          tx_d = ch[0];
        end
        DATA: begin
          state_d = bit_q == 3'd7 ? STOP : DATA;
          bit_d = bit_q + 3'd1;
          tx_d = bit_q == 3'd7 ? 1'b1 : ch[bit_q + 3'd1];
        end
        default: begin
          if (idx_q == 4'd13) begin
            state_d = IDLE;
            idx_d = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            state_d = START;
            idx_d = idx_q + 4'd1;
            tx_d = 1'b0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      res_q <= '0;
      nzc_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      res_q <= res_d;
      nzc_q <= nzc_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign tx = tx_q;
endmodule
